// File: rtl/vc_test_rand_sink.sv
`default_nettype none
// ============================================================================
//  Module      : vc_test_rand_sink
//  Description : Consumer end of a random-delay val/rdy test path. Accepts
//                messages, inserts LFSR-drawn in_rdy-low gaps between
//                transfers, checks each message in order against a loadable
//                expected-message table and reports progress and errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_test_rand_sink #(
  parameter int          p_msg_nbits = 8,
  parameter int          p_max_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'hACE1_2345
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   max_delay,
  input  logic [31:0]                   num_msgs,
  input  logic                          load_en,
  input  logic [$clog2(p_max_msgs)-1:0] load_addr,
  input  logic [p_msg_nbits-1:0]        load_data,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [p_msg_nbits-1:0]        in_msg,
  output logic                          done,
  output logic [31:0]                   num_recv,
  output logic [31:0]                   num_errors,
  output logic                          err,
  output logic [31:0]                   first_err_idx
);

  localparam int          c_AW   = $clog2(p_max_msgs);
  localparam logic [31:0] c_TAPS = 32'h8020_0003;
  localparam logic [31:0] c_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_READY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_n;
  logic [32:0]            r_cnt;
  logic [32:0]            w_cnt_n;
  logic [31:0]            r_lfsr;
  logic [31:0]            w_lfsr_n;
  logic [31:0]            r_num_recv;
  logic [31:0]            r_num_errors;
  logic                   r_err;
  logic [31:0]            r_first_err_idx;
  logic [p_msg_nbits-1:0] r_table [p_max_msgs];

  logic [32:0]            w_draw;
  logic                   w_xfer;
  logic                   w_mismatch;
  logic [p_msg_nbits-1:0] w_exp;

  // Galois step (right shift, feed taps back when the bit shifted out is 1)
  assign w_lfsr_n = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);

  // 33-bit modulus so max_delay = all-ones does not wrap the divisor to zero
  assign w_draw = {1'b0, r_lfsr} % ({1'b0, max_delay} + 33'd1);

  assign w_xfer     = (r_state == S_READY) && in_val;
  // Combinational read sees the pre-edge contents, so a same-cycle load at
  // this index does not affect the current comparison.
  assign w_exp      = r_table[r_num_recv[c_AW-1:0]];
  // Case inequality so an X/Z bit in the incoming message counts as an error
  assign w_mismatch = (in_msg !== w_exp);

  assign in_rdy        = (r_state == S_READY);
  assign done          = (r_state == S_DONE);
  assign num_recv      = r_num_recv;
  assign num_errors    = r_num_errors;
  assign err           = r_err;
  assign first_err_idx = r_first_err_idx;

  // Next-state and gap-counter logic
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_DELAY: begin
        if (r_cnt != 33'd0) begin
          w_cnt_n = r_cnt - 33'd1;
        end else if (r_num_recv == num_msgs) begin
          w_state_n = S_DONE;
        end else begin
          w_state_n = S_READY;
        end
      end
      S_READY: begin
        if (w_xfer) begin
          if (r_num_recv + 32'd1 == num_msgs) begin
            w_state_n = S_DONE;
          end else if (w_draw != 33'd0) begin
            // DELAY lasts cnt+1 cycles, so d-1 yields exactly d low cycles
            w_state_n = S_DELAY;
            w_cnt_n   = w_draw - 33'd1;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_DONE;
      end
      default: begin
        w_state_n = S_DELAY;
      end
    endcase
  end

  // State, gap counter and LFSR registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_DELAY;
      r_cnt   <= 33'd0;
      r_lfsr  <= p_seed;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_lfsr  <= w_lfsr_n;
    end
  end

  // Receive/error bookkeeping driven by accepted transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_recv      <= 32'd0;
      r_num_errors    <= 32'd0;
      r_err           <= 1'b0;
      r_first_err_idx <= c_NONE;
    end else begin
      r_err <= w_xfer && w_mismatch;
      if (w_xfer) begin
        r_num_recv <= r_num_recv + 32'd1;
        if (w_mismatch) begin
          r_num_errors <= r_num_errors + 32'd1;
          if (r_first_err_idx == c_NONE) begin
            r_first_err_idx <= r_num_recv;
          end
        end
      end
    end
  end

  // Expected-message table; deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_table[load_addr] <= load_data;
    end
  end

  a_in_val_known : assert property (@(posedge clk) disable iff (reset)
    !$isunknown(in_val));
  a_max_delay_known : assert property (@(posedge clk) disable iff (reset)
    !$isunknown(max_delay));
  a_num_msgs_range : assert property (@(posedge clk) disable iff (reset)
    num_msgs <= 32'(p_max_msgs));

endmodule
`default_nettype wire

// File: tb/tb_vc_test_rand_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_test_rand_sink
//  Description : Self-checking bench for vc_test_rand_sink with randomized
//                in_val and a cycle-level reference model of gaps/counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_test_rand_sink;

  localparam int          NB   = 8;
  localparam int          MAXM = 1024;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   max_delay = 32'd0;
  logic [31:0]   num_msgs = 32'd0;
  logic          load_en = 1'b0;
  logic [9:0]    load_addr = 10'd0;
  logic [NB-1:0] load_data = '0;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [NB-1:0] in_msg = '0;
  logic          done;
  logic [31:0]   num_recv;
  logic [31:0]   num_errors;
  logic          err;
  logic [31:0]   first_err_idx;

  vc_test_rand_sink #(
    .p_msg_nbits(NB),
    .p_max_msgs (MAXM),
    .p_seed     (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .max_delay    (max_delay),
    .num_msgs     (num_msgs),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_msg       (in_msg),
    .done         (done),
    .num_recv     (num_recv),
    .num_errors   (num_errors),
    .err          (err),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ready/done flags, remaining low cycles, counters
  logic [31:0]   m_lfsr;
  longint        m_gap;
  bit            m_rdy, m_done, m_err, m_xfer;
  int unsigned   m_recv, m_errors;
  logic [31:0]   m_first;
  logic [NB-1:0] m_tab [MAXM];

  logic [NB-1:0] src_tab [MAXM];
  logic [NB-1:0] snd     [MAXM];
  int            s_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Apply one clock edge of the specification's rules to the model
  task automatic model_edge();
    logic [63:0] d;
    m_xfer = 1'b0;
    if (reset) begin
      m_lfsr = SEED; m_gap = 1; m_rdy = 0; m_done = 0; m_err = 0;
      m_recv = 0; m_errors = 0; m_first = 32'hFFFF_FFFF;
    end else begin
      d = {32'd0, m_lfsr} % ({32'd0, max_delay} + 64'd1);
      m_err = 0;
      if (m_done) begin
        m_rdy = 0;
      end else if (m_rdy) begin
        if (in_val) begin
          m_xfer = 1'b1;
          if (in_msg !== m_tab[m_recv]) begin
            m_err = 1;
            m_errors++;
            if (m_first == 32'hFFFF_FFFF) m_first = m_recv;
          end
          m_recv++;
          if (m_recv == num_msgs) begin
            m_done = 1; m_rdy = 0;
          end else if (d != 0) begin
            m_rdy = 0; m_gap = longint'(d);
          end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) begin
          if (m_recv == num_msgs) m_done = 1;
          else m_rdy = 1;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    if (load_en) m_tab[load_addr] = load_data;
  endtask

  task automatic check_all();
    check_eq("in_rdy", {31'd0, in_rdy}, {31'd0, m_rdy});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("num_recv", num_recv, m_recv);
    check_eq("num_errors", num_errors, m_errors);
    check_eq("err", {31'd0, err}, {31'd0, m_err});
    check_eq("first_err_idx", first_err_idx, m_first);
  endtask

  // Inputs are set away from posedge; model advances, edge happens, check at negedge
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (m_xfer) s_idx++;
  endtask

  task automatic tick_drive(input int pct);
    in_val = ($urandom_range(99) < pct);
    in_msg = in_val ? snd[s_idx] : NB'($urandom);
    tick();
  endtask

  task automatic load_and_reset(input int n, input logic [31:0] maxd);
    num_msgs  = n;
    max_delay = maxd;
    reset     = 1'b1;
    in_val    = 1'b0;
    s_idx     = 0;
    for (int i = 0; i < n; i++) begin
      load_en = 1'b1; load_addr = 10'(i); load_data = src_tab[i];
      tick();
    end
    load_en = 1'b0;
    tick();
    reset = 1'b0;
    s_idx = 0;
  endtask

  task automatic run_test(input int n, input logic [31:0] maxd, input int pct, input int budget);
    int cyc;
    int ex;
    load_and_reset(n, maxd);
    cyc = 0;
    while (!m_done && cyc < budget) begin
      tick_drive(pct);
      cyc++;
    end
    check_eq("done_in_budget", {31'd0, done}, 32'd1);
    repeat (3) tick_drive(100);
    ex = 0;
    for (int i = 0; i < n; i++) if (snd[i] != src_tab[i]) ex++;
    check_eq("recv_final", num_recv, n);
    check_eq("errs_final", num_errors, ex);
  endtask

  initial begin
    // 1: zero delay, back-to-back
    for (int i = 0; i < 4; i++) begin src_tab[i] = NB'(i + 1); snd[i] = NB'(i + 1); end
    run_test(4, 32'd0, 100, 50);
    check_eq("t1_first", first_err_idx, 32'hFFFF_FFFF);

    // 2: random gaps up to 3, random in_val
    for (int i = 0; i < 100; i++) begin src_tab[i] = NB'($urandom); snd[i] = src_tab[i]; end
    run_test(100, 32'd3, 70, 2000);

    // 3: one corrupted message
    src_tab[0] = 8'hAA; src_tab[1] = 8'hBB; src_tab[2] = 8'hCC;
    snd[0] = 8'hAA; snd[1] = 8'hBD; snd[2] = 8'hCC;
    run_test(3, 32'd2, 80, 200);
    check_eq("t3_first", first_err_idx, 32'd1);

    // 4: nothing expected
    run_test(0, 32'd5, 100, 20);

    // 5: reset after two of five, then full rerun
    for (int i = 0; i < 5; i++) begin src_tab[i] = NB'($urandom); snd[i] = src_tab[i]; end
    load_and_reset(5, 32'd4);
    for (int c = 0; c < 200 && m_recv < 2; c++) tick_drive(100);
    check_eq("t5_two", num_recv, 32'd2);
    reset = 1'b1; in_val = 1'b1;
    tick();
    check_eq("t5_rst_rdy", {31'd0, in_rdy}, 32'd0);
    check_eq("t5_rst_recv", num_recv, 32'd0);
    check_eq("t5_rst_first", first_err_idx, 32'hFFFF_FFFF);
    run_test(5, 32'd4, 60, 300);

    // 6: full-range max_delay, the draw after the first transfer is huge
    src_tab[0] = 8'h11; src_tab[1] = 8'h22; snd[0] = 8'h11; snd[1] = 8'h22;
    load_and_reset(2, 32'hFFFF_FFFF);
    repeat (300) tick_drive(100);
    check_eq("t6_recv", num_recv, 32'd1);
    check_eq("t6_rdy", {31'd0, in_rdy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
